clk_divider_prog: RTL and testbench

// - Runtime-programmable integer clock divider; successor to the fixed even-only divider.
// - Generates clk_out at f(clk_in)/N for any N >= 2, including odd N.
// - Divisor changes are glitch-free and take effect only at a period boundary.
// - Provides a one-cycle tick strobe for logic that stays in the clk_in domain.

---
 rtl/clk_divider_prog.sv | 133 +++++++++++++
 tb/tb_clk_divider_prog.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider.
// clk_out = clk_in / div_cur for any divisor >= 2, including odd values.
// The high phase is ceil(N/2) cycles and the low phase is the rest.
// A new divisor is held in a shadow register and takes effect only at a
// period boundary, so clk_out never produces a runt pulse.
// Optional macro CLKDIV_CLEAN_STOP_EN changes how en=0 behaves:
//   undefined - en=0 freezes the counter and clk_out at their current values.
//   defined   - en=0 lets the current period finish, then parks clk_out low.
module clk_divider_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             load_pend
);

  localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(2);
  localparam logic [WIDTH-1:0] RESET_DIV = (DEFAULT_DIV < 2) ? MIN_DIV : WIDTH'(DEFAULT_DIV);

  // Divisors below 2 cannot form a period with both phases, so they are raised to 2.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] x);
    return (x < MIN_DIV) ? MIN_DIV : x;
  endfunction

  logic [WIDTH-1:0] count_q,     count_d;
  logic             clk_out_q,   clk_out_d;
  logic             tick_q,      tick_d;
  logic [WIDTH-1:0] div_cur_q,   div_cur_d;
  logic [WIDTH-1:0] shadow_q,    shadow_d;
  logic             load_pend_q, load_pend_d;

  logic [WIDTH:0]   hi_sum;
  logic [WIDTH-1:0] hi_cnt;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] div_in_clamped;
  logic             stopped;
  logic             run;
  logic             at_boundary;
  logic             apply_now;

  // Phase split point and last count of the period; the extra bit keeps
  // ceil(N/2) correct at the maximum divisor 2^WIDTH-1.
  assign hi_sum         = {1'b0, div_cur_q} + (WIDTH+1)'(1);
  assign hi_cnt         = hi_sum[WIDTH:1];
  assign last_cnt       = div_cur_q - WIDTH'(1);
  assign div_in_clamped = clamp_div(div_in);

  // Between a boundary and the next rising edge: a safe point to swap divisors.
  assign stopped = (count_q == '0) && !clk_out_q;

`ifdef CLKDIV_CLEAN_STOP_EN
  // Keep running until the period in progress has finished.
  assign run = en || !stopped;
`else
  // Freeze exactly where we are.
  assign run = en;
`endif

  assign at_boundary = run && (count_q == last_cnt);
  assign apply_now   = at_boundary || (!en && stopped);

  // Next-state logic: waveform generation, counter and divisor hand-over.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    count_d     = count_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    div_cur_d   = div_cur_q;
    shadow_d    = shadow_q;
    load_pend_d = load_pend_q;

    if (run) begin
      if (count_q == '0) begin
        clk_out_d = 1'b1;
        tick_d    = 1'b1;
      end else if (count_q == hi_cnt) begin
        clk_out_d = 1'b0;
      end
      count_d = at_boundary ? '0 : count_q + WIDTH'(1);
    end

    if (apply_now) begin
      // A load arriving on the hand-over edge itself bypasses the shadow.
      if (div_load) begin
        div_cur_d   = div_in_clamped;
        shadow_d    = div_in_clamped;
        load_pend_d = 1'b0;
      end else if (load_pend_q) begin
        div_cur_d   = shadow_q;
        load_pend_d = 1'b0;
      end
    end else if (div_load) begin
      // Last load before the boundary wins.
      shadow_d    = div_in_clamped;
      load_pend_d = 1'b1;
    end
  end

  // State registers; reset discards any pending divisor.
  always_ff @(posedge clk_in or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge value of the others regardless of statement order.
    if (!rst_n) begin
      count_q     <= '0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      div_cur_q   <= RESET_DIV;
      shadow_q    <= RESET_DIV;
      load_pend_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      div_cur_q   <= div_cur_d;
      shadow_q    <= shadow_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign div_cur   = div_cur_q;
  assign load_pend = load_pend_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog.
// The reference model describes each period as a queue of clk_out levels
// (ceil(N/2) ones then zeros) built when a period starts and consumed one
// entry per running edge; an empty queue marks the period boundary.
// Honours CLKDIV_CLEAN_STOP_EN the same way the design does.
module tb_clk_divider_prog;

  localparam int WIDTH = 16;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_cur;
  logic             load_pend;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit m_wave[$];
  bit m_clk;
  bit m_tick;
  bit m_pend;
  int m_n;
  int m_shadow;

  clk_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .div_in    (div_in),
    .div_load  (div_load),
    .clk_out   (clk_out),
    .tick      (tick),
    .div_cur   (div_cur),
    .load_pend (load_pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampv(input int x);
    return (x < 2) ? 2 : x;
  endfunction

  task automatic model_reset();
    m_wave.delete();
    m_clk    = 1'b0;
    m_tick   = 1'b0;
    m_pend   = 1'b0;
    m_n      = 2;
    m_shadow = 2;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".clk_out"},   clk_out,   m_clk);
    check({tag, ".tick"},      tick,      m_tick);
    check({tag, ".div_cur"},   div_cur,   m_n);
    check({tag, ".load_pend"}, load_pend, m_pend);
  endtask

  // One clock: drive inputs, advance the model across the edge, compare at negedge.
  task automatic step(input bit e, input bit ld, input int din);
    bit stopped;
    bit run;
    bit boundary;
    en       = e;
    div_load = ld;
    div_in   = din[WIDTH-1:0];
    @(posedge clk_in);
    stopped = (m_wave.size() == 0) && !m_clk;
`ifdef CLKDIV_CLEAN_STOP_EN
    run = e || !stopped;
`else
    run = e;
`endif
    m_tick   = 1'b0;
    boundary = 1'b0;
    if (run) begin
      if (m_wave.size() == 0) begin
        for (int i = 0; i < m_n; i++) m_wave.push_back(i < (m_n + 1) / 2);
        m_tick = 1'b1;
      end
      m_clk    = m_wave.pop_front();
      boundary = (m_wave.size() == 0);
    end
    if (boundary || (!e && stopped)) begin
      if (ld) begin
        m_n      = clampv(din);
        m_shadow = m_n;
        m_pend   = 1'b0;
      end else if (m_pend) begin
        m_n    = m_shadow;
        m_pend = 1'b0;
      end
    end else if (ld) begin
      m_shadow = clampv(din);
      m_pend   = 1'b1;
    end
    @(negedge clk_in);
    div_load = 1'b0;
    check_all("step");
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.clk_out",   clk_out,   0);
    check("rst.tick",      tick,      0);
    check("rst.div_cur",   div_cur,   2);
    check("rst.load_pend", load_pend, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  // Run enabled until the pending divisor is in force, with a cycle budget.
  task automatic run_until_applied();
    for (int i = 0; i < 100 && m_pend; i++) step(1'b1, 1'b0, 0);
    check("apply_timeout", load_pend, 0);
  endtask

  // Run enabled until the next edge is the period boundary.
  task automatic run_to_last(input string tag);
    int i;
    i = 0;
    while (!(m_wave.size() == 1) && i < 100) begin
      step(1'b1, 1'b0, 0);
      i++;
    end
    check({tag, ".to_last_timeout"}, (i < 100), 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    model_reset();
    @(negedge clk_in);
    check_all("reset");
    rst_n = 1'b1;

    // Default divisor 2: toggles every cycle, tick on every rising edge.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 0);
      check("div2.toggle", clk_out, (i % 2 == 0));
      check("div2.tick",   tick,    (i % 2 == 0));
    end

    // Switch to 4, then load 5 mid-period.
    step(1'b1, 1'b1, 4);
    run_until_applied();
    check("div4.cur", div_cur, 4);
    run_to_last("div4");
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    check("load5.pend", load_pend, 1);
    check("load5.old",  div_cur,   4);
    run_until_applied();
    check("load5.cur", div_cur, 5);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0);

    // Clamp of 0 and 1; last-wins for 7 then 9.
    step(1'b1, 1'b1, 0);
    run_until_applied();
    check("clamp0", div_cur, 2);
    step(1'b1, 1'b1, 1);
    run_until_applied();
    check("clamp1", div_cur, 2);
    run_to_last("lw");
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 7);
    step(1'b1, 1'b1, 9);
    run_until_applied();
    check("last_wins", div_cur, 9);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0);

    // Load exactly on the boundary edge: bypasses the shadow.
    run_to_last("bnd");
    step(1'b1, 1'b1, 3);
    check("bnd.pend", load_pend, 0);
    check("bnd.cur",  div_cur,   3);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0);

    // en low for 10 cycles in the middle of a high phase of N=5.
    step(1'b1, 1'b1, 5);
    run_until_applied();
    run_to_last("hold");
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0);
`ifdef CLKDIV_CLEAN_STOP_EN
    check("hold.parked", clk_out, 0);
`else
    check("hold.frozen", clk_out, 1);
`endif
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0);

    // Reset in the middle of a period with a load pending.
    step(1'b1, 1'b1, 8);
    check("rst_pend.pre", load_pend, 1);
    async_reset();
    step(1'b1, 1'b0, 0);
    check("rst.first_rise", clk_out, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0);

    // Maximum divisor applied while stopped after reset.
    async_reset();
    step(1'b0, 1'b1, 65535);
    check("max.cur", div_cur, 65535);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0);
    check("max.high", clk_out, 1);
    async_reset();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit e;
      bit ld;
      int d;
      e  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 9) == 0);
      d  = $urandom_range(0, 12);
      if ($urandom_range(0, 299) == 0) async_reset();
      else step(e, ld, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
